avs_pixel_memory_slave: RTL

AVS_PIXEL_MEMORY_SLAVE -- requirements
Module: avs_pixel_memory_slave

---
 rtl/avs_pixel_memory_slave.sv | 138 +++++++++++++
 1 files changed

// File: rtl/avs_pixel_memory_slave.sv
// avs_pixel_memory_slave: byte-wide Avalon-MM pixel memory slave with fixed wait states,
// transfer counters and a sticky protocol/range error flag.  Rev 1.0
`default_nettype none

module avs_pixel_memory_slave #(
  parameter int AVS_AVALONSLAVE_DATA_WIDTH    = 8,
  parameter int AVS_AVALONSLAVE_ADDRESS_WIDTH = 18,
  parameter int MEM_DEPTH_LOG2                = 10,
  parameter int WAIT_CYCLES                   = 2
) (
  input  logic                                     CSI_CLOCK_CLK,
  input  logic                                     CSI_CLOCK_RESET_N,
  input  logic [AVS_AVALONSLAVE_ADDRESS_WIDTH-1:0] AVS_AVALONSLAVE_ADDRESS,
  input  logic                                     AVS_AVALONSLAVE_READ,
  input  logic                                     AVS_AVALONSLAVE_WRITE,
  input  logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]    AVS_AVALONSLAVE_WRITEDATA,
  output logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]    AVS_AVALONSLAVE_READDATA,
  output logic                                     AVS_AVALONSLAVE_WAITREQUEST,
  output logic [15:0]                              RD_COUNT,
  output logic [15:0]                              WR_COUNT,
  output logic                                     ERR_FLAG
);

  localparam int         DW        = AVS_AVALONSLAVE_DATA_WIDTH;
  localparam int         MD        = MEM_DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic [MD-1:0]   cap_idx;
  logic [DW-1:0]   cap_data;
  logic            cap_rd;
  logic            cap_wr;
  logic            cap_oor;
  logic            cap_bad;
  logic [DW-1:0]   rdata;
  logic [15:0]     rd_cnt;
  logic [15:0]     wr_cnt;
  logic            err;

  logic [DW-1:0]   mem [2**MD];

  logic            req_any;
  logic            req_rd;
  logic            req_wr;
  logic            req_oor;
  logic [MD-1:0]   req_idx;

  assign req_any = AVS_AVALONSLAVE_READ | AVS_AVALONSLAVE_WRITE;
  assign req_rd  = AVS_AVALONSLAVE_READ & ~AVS_AVALONSLAVE_WRITE;
  assign req_wr  = AVS_AVALONSLAVE_WRITE & ~AVS_AVALONSLAVE_READ;
  assign req_idx = AVS_AVALONSLAVE_ADDRESS[MD-1:0];
  // Any address bit at or above the implemented depth marks the access out of range.
  assign req_oor = |(AVS_AVALONSLAVE_ADDRESS >> MD);

  always_ff @(posedge CSI_CLOCK_CLK or negedge CSI_CLOCK_RESET_N) begin
    if (!CSI_CLOCK_RESET_N) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      cap_idx  <= '0;
      cap_data <= '0;
      cap_rd   <= 1'b0;
      cap_wr   <= 1'b0;
      cap_oor  <= 1'b0;
      cap_bad  <= 1'b0;
      rdata    <= '0;
      rd_cnt   <= 16'd0;
      wr_cnt   <= 16'd0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            cap_idx  <= req_idx;
            cap_data <= AVS_AVALONSLAVE_WRITEDATA;
            cap_rd   <= req_rd;
            cap_wr   <= req_wr;
            cap_oor  <= req_oor;
            cap_bad  <= AVS_AVALONSLAVE_READ & AVS_AVALONSLAVE_WRITE;
            wait_cnt <= WAIT_INIT;
            if (WAIT_CYCLES == 0) begin
              state <= ACK;
              if (req_rd)
                rdata <= req_oor ? '0 : mem[req_idx];
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req_any) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            err      <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) begin
              state <= ACK;
              if (cap_rd)
                rdata <= cap_oor ? '0 : mem[cap_idx];
            end
          end
        end
        ACK: begin
          state <= IDLE;
          if (cap_rd && rd_cnt != 16'hFFFF)
            rd_cnt <= rd_cnt + 16'd1;
          if (cap_wr && wr_cnt != 16'hFFFF)
            wr_cnt <= wr_cnt + 16'd1;
          if (cap_oor || cap_bad)
            err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is never reset; a reset-abandoned transfer cannot reach the ACK-gated write.
  always_ff @(posedge CSI_CLOCK_CLK) begin
    if (CSI_CLOCK_RESET_N && state == ACK && cap_wr && !cap_oor)
      mem[cap_idx] <= cap_data;
  end

  assign AVS_AVALONSLAVE_WAITREQUEST = (state != ACK);
  assign AVS_AVALONSLAVE_READDATA    = rdata;
  assign RD_COUNT                    = rd_cnt;
  assign WR_COUNT                    = wr_cnt;
  assign ERR_FLAG                    = err;

endmodule

`default_nettype wire
